// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: N-master to 1-slave Wishbone classic arbiter.
// Round-robin grant, bus lock while cyc is held, per-strobe watchdog.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   m_*_i               packed per-master request buses (slice i = master i)
//   m_dat_o             slave read data broadcast to every master
//   m_ack/err/rty_o     per-master responses, only the owner sees them
//   s_*_o / s_*_i       slave request / response
//   grant_o, busy_o     registered one-hot owner, OR of grant_o
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 32,
    parameter int SEL_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT     = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [NUM_MASTERS-1:0]            m_rty_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    output logic                              s_we_o,
    output logic [SEL_WIDTH-1:0]              s_sel_o,
    output logic                              s_stb_o,
    output logic                              s_cyc_o,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    input  logic                              s_rty_i,
    output logic [NUM_MASTERS-1:0]            grant_o,
    output logic                              busy_o
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);

    typedef enum logic {
        S_IDLE,
        S_OWNED
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [IW-1:0]          r_last;
    logic [IW-1:0]          w_last_nxt;
    logic [IW-1:0]          w_owner;
    logic [IW-1:0]          w_idx;
    logic [NUM_MASTERS-1:0] w_pick;
    logic                   w_found;
    logic                   w_own_cyc;
    logic                   w_own_stb;
    logic                   w_resp;
    logic                   w_wd_clr;
    logic                   w_wd_hit;

    assign w_own_cyc = |(r_grant & m_cyc_i);
    assign w_own_stb = |(r_grant & m_stb_i);
    assign w_resp    = s_ack_i | s_err_i | s_rty_i;

    // Owner index, used to remember who released last.
    always_comb begin
        w_owner = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) begin
                w_owner = IW'(i);
            end
        end
    end

    // First requester searching upward from last+1, wrapping.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_idx = IW'((int'(r_last) + k) % NUM_MASTERS);
            if (!w_found && m_cyc_i[w_idx]) begin
                w_pick[w_idx] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= LAST_RST;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        unique case (r_state)
            S_IDLE: begin
                if (|m_cyc_i) begin
                    w_state_nxt = S_OWNED;
                    w_grant_nxt = w_pick;
                end
            end
            S_OWNED: begin
                // Release always passes through IDLE, so a
                // re-request from the old owner ranks last.
                if (!w_own_cyc) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_last_nxt  = w_owner;
                end
            end
        endcase
    end

    assign w_wd_clr = !w_own_stb || w_resp || w_wd_hit ||
                      (w_grant_nxt != r_grant);

    generate
        if (TIMEOUT > 0) begin : g_wd
            logic [WW-1:0] r_wd;

            always_ff @(posedge clk) begin
                if (rst || w_wd_clr) begin
                    r_wd <= '0;
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
            end

            assign w_wd_hit = w_own_stb && (r_wd == WW'(TIMEOUT));
        end else begin : g_nowd
            assign w_wd_hit = 1'b0;
        end
    endgenerate

    // Output logic: grant is nonzero only in OWNED, so the
    // one-hot mux doubles as the idle zeroing.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) begin
                s_adr_o    = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_dat_o    = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                s_sel_o    = m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
                s_we_o     = m_we_i[i];
                s_cyc_o    = m_cyc_i[i];
                // Watchdog error overrides any late slave response.
                s_stb_o    = m_stb_i[i] & ~w_wd_hit;
                m_ack_o[i] = s_ack_i & ~w_wd_hit;
                m_rty_o[i] = s_rty_i & ~w_wd_hit;
                m_err_o[i] = s_err_i | w_wd_hit;
            end
        end
    end

    assign m_dat_o = s_dat_i;
    assign grant_o = r_grant;
    assign busy_o  = |r_grant;

endmodule
